// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset owner, lock monitor and ordered SDRAM/system reset release
`timescale 1ns/1ps

module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int SDRAM_WAIT_CYCLES   = 10000,
  parameter int MAX_RETRIES         = 7,
  parameter int CNT_W               = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart_req,
  output logic       pll_rst,
  output logic       sdram_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [2:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_SDRAM_REL,
    S_RUN,
    S_FAIL
  } state_t;

  // Terminal counts: each phase ends on the cycle its counter holds N-1.
  localparam logic [CNT_W-1:0] C_PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_SDRAM_LAST  = CNT_W'(SDRAM_WAIT_CYCLES - 1);
  localparam logic [2:0]       C_MAX_RETRY   = 3'(MAX_RETRIES);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_retry;
  logic [7:0]       r_loss;
  logic             r_sync1;
  logic             r_lock_s;
  logic             r_pll_rst;
  logic             r_sdram_rst;
  logic             r_sys_rst;
  logic             r_ready;
  logic             r_fail;

  assign pll_rst       = r_pll_rst;
  assign sdram_rst     = r_sdram_rst;
  assign sys_rst       = r_sys_rst;
  assign ready         = r_ready;
  assign fail          = r_fail;
  assign retry_cnt     = r_retry;
  assign lock_loss_cnt = r_loss;

  // Bring the asynchronous PLL lock flag into the refclk domain.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= pll_locked;
      r_lock_s <= r_sync1;
    end
  end

  // Sequencer FSM; reset outputs are decoded from the current state, so they trail it by one cycle.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state     <= S_PLL_RST;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_loss      <= '0;
      r_pll_rst   <= 1'b1;
      r_sdram_rst <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_pll_rst   <= (r_state == S_PLL_RST) || (r_state == S_FAIL);
      r_sdram_rst <= !((r_state == S_SDRAM_REL) || (r_state == S_RUN));
      r_sys_rst   <= (r_state != S_RUN);
      r_ready     <= (r_state == S_RUN);
      r_fail      <= (r_state == S_FAIL);
      r_cnt       <= r_cnt + CNT_W'(1);

      if (restart_req) begin
        // A restart overrides everything, including a lock loss seen this cycle.
        r_state <= S_PLL_RST;
        r_cnt   <= '0;
        r_retry <= '0;
      end else begin
        case (r_state)
          S_PLL_RST: begin
            if (r_cnt == C_PLL_LAST) begin
              r_state <= S_WAIT_LOCK;
              r_cnt   <= '0;
            end
          end
          S_WAIT_LOCK: begin
            // Lock is checked first so it wins over a coincident timeout.
            if (r_lock_s) begin
              r_state <= S_STABLE;
              r_cnt   <= '0;
            end else if (r_cnt == C_TIMEOUT) begin
              r_cnt <= '0;
              if (r_retry < C_MAX_RETRY) begin
                r_retry <= r_retry + 3'd1;
                r_state <= S_PLL_RST;
              end else begin
                r_state <= S_FAIL;
              end
            end
          end
          S_STABLE: begin
            if (!r_lock_s) begin
              r_state <= S_WAIT_LOCK;
              r_cnt   <= '0;
            end else if (r_cnt == C_STABLE_LAST) begin
              r_state <= S_SDRAM_REL;
              r_cnt   <= '0;
            end
          end
          S_SDRAM_REL: begin
            if (!r_lock_s) begin
              r_state <= S_PLL_RST;
              r_cnt   <= '0;
              if (r_loss != 8'hFF) r_loss <= r_loss + 8'd1;
            end else if (r_cnt == C_SDRAM_LAST) begin
              r_state <= S_RUN;
              r_cnt   <= '0;
              r_retry <= '0;
            end
          end
          S_RUN: begin
            r_cnt <= '0;
            if (!r_lock_s) begin
              r_state <= S_PLL_RST;
              if (r_loss != 8'hFF) r_loss <= r_loss + 8'd1;
            end
          end
          S_FAIL: begin
            r_cnt <= '0;
          end
          default: begin
            r_state <= S_PLL_RST;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
